// File: rtl/i_memory_prog.sv
`default_nettype none
// ============================================================================
//  Module   : i_memory_prog
//  Purpose  : Writable instruction store for the core's fetch stage.
//             Fetches use a valid/ready request/response handshake with a
//             registered one-cycle read latency. The response holds while it
//             is stalled. A program-load port fills the array at run time,
//             and a same-cycle write to the fetched address bypasses to the
//             response. Fetches at or beyond DEPTH return NOP_WORD and raise
//             rsp_err. flush drops the pending or arriving response.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1       rising-edge clock
//    rst_n        in   1       asynchronous active-low reset
//    wr_en        in   1       program-load write strobe
//    wr_addr      in   ADDR_W  program-load address
//    wr_data      in   DATA_W  program-load data
//    req_valid    in   1       fetch request valid
//    req_ready    out  1       fetch request can be accepted this cycle
//    req_addr     in   ADDR_W  fetch address (pc)
//    rsp_valid    out  1       instruction valid
//    rsp_ready    in   1       fetch stage accepts the instruction
//    instruction  out  DATA_W  fetched word
//    rsp_addr     out  ADDR_W  address of the fetched word
//    rsp_err      out  1       fetch address was >= DEPTH
//    flush        in   1       discard the pending or arriving response
//    fetch_cnt    out  16      count of delivered responses (wraps)
// ============================================================================
module i_memory_prog #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 4,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              flush,
    output logic [15:0]       fetch_cnt
);

    // The array spans the whole address space so that every index is
    // exactly ADDR_W bits wide. Rows at or beyond DEPTH are never written
    // or read, so synthesis trims them.
    localparam int              c_SLOTS = 1 << ADDR_W;

    // DEPTH may equal 2**ADDR_W, which needs one extra bit. Addresses are
    // zero-extended to this width, so the range check is unsigned and never
    // truncated.
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [0:c_SLOTS-1];

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_instruction;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic              r_rsp_err;
    logic [15:0]       r_fetch_cnt;

    logic              w_wr_in_range;
    logic              w_req_in_range;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_consume;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_rd_err;

    assign w_wr_in_range  = ({1'b0, wr_addr}  < c_DEPTH);
    assign w_req_in_range = ({1'b0, req_addr} < c_DEPTH);

    // Readiness depends only on the output register, never on req_valid.
    // This keeps the handshake free of combinational loops.
    assign w_req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept    = req_valid && w_req_ready && !flush;
    assign w_consume   = r_rsp_valid && rsp_ready;

    // Word selected for an accepted request. A same-cycle write to the
    // fetched address wins over the array (write-first). Equal addresses
    // with an in-range req_addr imply an in-range wr_addr, so the write
    // itself also lands.
    always_comb begin
        w_rd_word = NOP_WORD;
        w_rd_err  = 1'b1;
        if (w_req_in_range) begin
            w_rd_err = 1'b0;
            if (wr_en && (wr_addr == req_addr)) begin
                w_rd_word = wr_data;
            end else begin
                w_rd_word = r_mem[req_addr];
            end
        end
    end

    // Program-load port. The array has no reset, so its contents survive
    // rst_n. Writes go through whatever the handshake or reset is doing.
    always_ff @(posedge clk) begin
        if (wr_en && w_wr_in_range) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Response register. flush outranks both a new acceptance and a
    // consumption. When flush is high, w_accept is already low, so only
    // rsp_valid is cleared and the payload keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid   <= 1'b0;
            r_instruction <= '0;
            r_rsp_addr    <= '0;
            r_rsp_err     <= 1'b0;
        end else if (flush) begin
            r_rsp_valid   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid   <= 1'b1;
            r_instruction <= w_rd_word;
            r_rsp_addr    <= req_addr;
            r_rsp_err     <= w_rd_err;
        end else if (w_consume) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    // A response only counts as delivered if it is not flushed in the
    // same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
        end else if (w_consume && !flush) begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign instruction = r_instruction;
    assign rsp_addr    = r_rsp_addr;
    assign rsp_err     = r_rsp_err;
    assign fetch_cnt   = r_fetch_cnt;

endmodule
`default_nettype wire
